// File: rtl/filter_window_ctrl.sv
// filter_window_ctrl: camera pixel stream -> 3x3 line-buffer write coordinates, window-valid
// alignment and end-of-frame flush. Define FILTER_WINCTRL_STATS_EN to add frame_cnt/err_cnt outputs.
//
// state  | meaning
// IDLE   | waiting for vsync_in with enable=1
// ACTIVE | writing camera pixels, tracking x/y
// FLUSH  | emitting ROW_OFS synthetic lines so the last rows reach the window centre
module filter_window_ctrl #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int PIX_W   = 12,
    parameter int ROW_OFS = 2,
    parameter int LAT     = 1
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             vsync_in,
    input  logic             de_in,
    input  logic [PIX_W-1:0] data_in,
    output logic [9:0]       lb_x,
    output logic [9:0]       lb_y,
    output logic [PIX_W-1:0] lb_data,
    output logic             win_valid,
    output logic [9:0]       win_x,
    output logic [9:0]       win_y,
    output logic             frame_done,
    output logic             err_line,
    output logic             err_frame,
`ifdef FILTER_WINCTRL_STATS_EN
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic [1:0]       state_o
);

    localparam logic [9:0] C_HACT   = 10'(H_ACT);
    localparam logic [9:0] C_HLAST  = 10'(H_ACT - 1);
    localparam logic [9:0] C_VACT   = 10'(V_ACT);
    localparam logic [9:0] C_VLAST  = 10'(V_ACT - 1);
    localparam logic [9:0] C_ROWOFS = 10'(ROW_OFS);
    localparam logic [9:0] C_FYBASE = 10'(V_ACT - ROW_OFS);
    localparam logic [9:0] C_FYLAST = 10'(ROW_OFS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [9:0]       r_x, r_y, r_fx, r_fy;
    logic [9:0]       w_x_nx, w_y_nx, w_fx_nx, w_fy_nx;
    logic             r_de_d;
    logic             r_err_line, r_err_frame, w_err_line_nx, w_err_frame_nx;
    logic [9:0]       r_lb_x, r_lb_y, w_lb_x_nx, w_lb_y_nx;
    logic [PIX_W-1:0] r_lb_data, w_lb_data_nx;
    logic             r_s0_v, r_s0_last, w_s0_v_nx, w_s0_last_nx;
    logic [9:0]       r_s0_x, r_s0_y, w_s0_x_nx, w_s0_y_nx;
    logic             r_pv    [LAT];
    logic             r_plast [LAT];
    logic [9:0]       r_px    [LAT];
    logic [9:0]       r_py    [LAT];
    logic             r_frame_done;
    logic             w_restart, w_line_end;

    assign w_restart  = vsync_in && ((r_state != S_IDLE) || enable);
    assign w_line_end = r_de_d && !de_in;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_x_nx         = r_x;
        w_y_nx         = r_y;
        w_fx_nx        = r_fx;
        w_fy_nx        = r_fy;
        w_err_line_nx  = r_err_line;
        w_err_frame_nx = r_err_frame;
        w_lb_x_nx      = C_HACT;
        w_lb_y_nx      = r_lb_y;
        w_lb_data_nx   = r_lb_data;
        w_s0_v_nx      = 1'b0;
        w_s0_last_nx   = 1'b0;
        w_s0_x_nx      = r_s0_x;
        w_s0_y_nx      = r_s0_y;

        if (w_restart) begin
            // vsync wins over everything; a coincident pixel becomes (0,0) of the new frame
            w_state_nx = S_ACTIVE;
            w_x_nx     = '0;
            w_y_nx     = '0;
            w_fx_nx    = '0;
            w_fy_nx    = '0;
            if (r_state == S_IDLE) begin
                w_err_line_nx  = 1'b0;
                w_err_frame_nx = 1'b0;
            end else begin
                w_err_frame_nx = 1'b1;
            end
            if (de_in) begin
                w_lb_x_nx    = '0;
                w_lb_y_nx    = '0;
                w_lb_data_nx = data_in;
                w_x_nx       = 10'd1;
                w_s0_v_nx    = (C_ROWOFS == 10'd0);
                w_s0_x_nx    = '0;
                w_s0_y_nx    = '0;
            end
        end else begin
            case (r_state)
                S_ACTIVE: begin
                    if (de_in) begin
                        if (r_x < C_HACT && r_y < C_VACT) begin
                            w_lb_x_nx    = r_x;
                            w_lb_y_nx    = r_y;
                            w_lb_data_nx = data_in;
                            w_x_nx       = r_x + 10'd1;
                            w_s0_v_nx    = (r_y >= C_ROWOFS);
                            w_s0_x_nx    = r_x;
                            w_s0_y_nx    = r_y - C_ROWOFS;
                        end else begin
                            w_err_line_nx = 1'b1;
                        end
                    end else if (w_line_end) begin
                        if (r_x != C_HACT) w_err_line_nx = 1'b1;
                        w_x_nx = '0;
                        if (r_y < C_VACT) w_y_nx = r_y + 10'd1;
                        if (r_y >= C_VLAST) begin
                            w_state_nx = S_FLUSH;
                            w_fx_nx    = '0;
                            w_fy_nx    = '0;
                        end
                    end
                end
                S_FLUSH: begin
                    w_lb_x_nx    = r_fx;
                    w_lb_y_nx    = C_VLAST;
                    w_lb_data_nx = '0;
                    w_s0_v_nx    = 1'b1;
                    w_s0_x_nx    = r_fx;
                    w_s0_y_nx    = C_FYBASE + r_fy;
                    if (r_fx == C_HLAST) begin
                        w_fx_nx = '0;
                        if (r_fy == C_FYLAST) begin
                            w_s0_last_nx = 1'b1;
                            w_state_nx   = S_IDLE;
                            w_fy_nx      = '0;
                        end else begin
                            w_fy_nx = r_fy + 10'd1;
                        end
                    end else begin
                        w_fx_nx = r_fx + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // stage0 is aligned with lb_*; the LAT-deep shift register follows it
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_fx         <= '0;
            r_fy         <= '0;
            r_de_d       <= 1'b0;
            r_err_line   <= 1'b0;
            r_err_frame  <= 1'b0;
            r_lb_x       <= C_HACT;
            r_lb_y       <= '0;
            r_lb_data    <= '0;
            r_s0_v       <= 1'b0;
            r_s0_last    <= 1'b0;
            r_s0_x       <= '0;
            r_s0_y       <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                r_pv[i]    <= 1'b0;
                r_plast[i] <= 1'b0;
                r_px[i]    <= '0;
                r_py[i]    <= '0;
            end
        end else begin
            r_x          <= w_x_nx;
            r_y          <= w_y_nx;
            r_fx         <= w_fx_nx;
            r_fy         <= w_fy_nx;
            r_de_d       <= de_in;
            r_err_line   <= w_err_line_nx;
            r_err_frame  <= w_err_frame_nx;
            r_lb_x       <= w_lb_x_nx;
            r_lb_y       <= w_lb_y_nx;
            r_lb_data    <= w_lb_data_nx;
            r_s0_v       <= w_s0_v_nx;
            r_s0_last    <= w_s0_last_nx;
            r_s0_x       <= w_s0_x_nx;
            r_s0_y       <= w_s0_y_nx;
            r_pv[0]      <= r_s0_v;
            r_plast[0]   <= r_s0_last;
            r_px[0]      <= r_s0_x;
            r_py[0]      <= r_s0_y;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_plast[i] <= r_plast[i-1];
                r_px[i]    <= r_px[i-1];
                r_py[i]    <= r_py[i-1];
            end
            r_frame_done <= r_plast[LAT-1];
        end
    end

`ifdef FILTER_WINCTRL_STATS_EN
    logic [15:0] r_frame_cnt, r_err_cnt;
    logic        w_err_set;

    assign w_err_set = (w_err_line_nx && !r_err_line) || (w_err_frame_nx && !r_err_frame);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_frame_done && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_err_set && r_err_cnt != 16'hFFFF)      r_err_cnt   <= r_err_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

    assign lb_x       = r_lb_x;
    assign lb_y       = r_lb_y;
    assign lb_data    = r_lb_data;
    assign win_valid  = r_pv[LAT-1];
    assign win_x      = r_px[LAT-1];
    assign win_y      = r_py[LAT-1];
    assign frame_done = r_frame_done;
    assign err_line   = r_err_line;
    assign err_frame  = r_err_frame;
    assign state_o    = r_state;

endmodule
